// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: round-robin arbiter that serialises set/clear requests onto one SR latch
// (optional SR_LATCH_CTRL_SKIP_REDUNDANT_EN: skip the latch sequence when op already matches q_shadow)
module sr_latch_ctrl #(
   parameter int N_REQ     = 4,
   parameter int PULSE_CYC = 2,
   parameter int IDW       = $clog2(N_REQ)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [N_REQ-1:0] i_req_set,
   input  logic [N_REQ-1:0] i_req_clr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IDW-1:0]   o_gnt_id,
   output logic             o_done,
   output logic             o_busy,
   output logic [N_REQ-1:0] o_illegal_req,
   output logic             o_control,
   output logic             o_s,
   output logic             o_r,
   output logic             o_q_shadow
);
   localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
   typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
   state_t           r_state;
   logic [IDW-1:0]   r_ptr, r_gnt_id;
   logic [CW-1:0]    r_cnt;
   logic [N_REQ-1:0] r_gnt, r_illegal;
   logic             r_op, r_done, r_busy, r_control, r_s, r_r, r_q_shadow;
   logic [N_REQ-1:0] w_elig;
   logic             w_found, w_op;
   logic [IDW-1:0]   w_win, w_ptr_nxt;
   assign w_elig = i_req_set ^ i_req_clr;
   // first eligible requester searching upward from ptr, wrapping; lowest offset wins
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (w_elig[(int'(r_ptr) + k) % N_REQ]) begin
            w_found = 1'b1;
            w_win   = IDW'((int'(r_ptr) + k) % N_REQ);
         end
      end
   end
   assign w_op      = i_req_set[w_win];
   assign w_ptr_nxt = (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
   // sequencer: s/r are set up one cycle before control rises and held one cycle after it falls
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_cnt      <= '0;
         r_gnt      <= '0;
         r_gnt_id   <= '0;
         r_op       <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
         r_illegal  <= '0;
         r_control  <= 1'b0;
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_q_shadow <= 1'b0;
      end else begin
         r_illegal <= i_req_set & i_req_clr;
         case (r_state)
            IDLE: if (w_found) begin
               r_gnt    <= N_REQ'(1) << w_win;
               r_gnt_id <= w_win;
               r_op     <= w_op;
               r_busy   <= 1'b1;
               r_ptr    <= w_ptr_nxt;
`ifdef SR_LATCH_CTRL_SKIP_REDUNDANT_EN
               if (w_op == r_q_shadow) begin
                  r_state <= HOLD;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= SETUP;
                  r_s     <= w_op;
                  r_r     <= ~w_op;
               end
`else
               r_state <= SETUP;
               r_s     <= w_op;
               r_r     <= ~w_op;
`endif
            end
            SETUP: begin
               r_state   <= PULSE;
               r_control <= 1'b1;
               r_cnt     <= '0;
            end
            PULSE: if (r_cnt == CW'(PULSE_CYC - 1)) begin
               r_state   <= HOLD;
               r_control <= 1'b0;
               r_done    <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            HOLD: begin
               r_state    <= IDLE;
               r_done     <= 1'b0;
               r_q_shadow <= r_op;
               r_gnt      <= '0;
               r_s        <= 1'b0;
               r_r        <= 1'b0;
               r_busy     <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign o_gnt         = r_gnt;
   assign o_gnt_id      = r_gnt_id;
   assign o_done        = r_done;
   assign o_busy        = r_busy;
   assign o_illegal_req = r_illegal;
   assign o_control     = r_control;
   assign o_s           = r_s;
   assign o_r           = r_r;
   assign o_q_shadow    = r_q_shadow;
endmodule

// File: doc/sr_latch_ctrl.md
Name: sr_latch_ctrl

Overview:
- Round-robin controller sharing one SR latch between N_REQ requesters; each requester asks to set or clear the latch.
- Serialises requests and drives the latch's control/s/r pins with a safe sequence: s/r set up, control pulsed, s/r held.
- Guarantees s=r=1 never reaches the latch.
- Keeps a shadow copy of the latch state; sits between requesters and the latch instance.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- PULSE_CYC, 2, cycles control is held high per operation (>=1).
- IDW, $clog2(N_REQ), width of grant index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_set  in  N_REQ  bit i: requester i asks to set the latch.
- req_clr  in  N_REQ  bit i: requester i asks to clear the latch.
- gnt  out  N_REQ  one-hot grant, held for the whole operation.
- gnt_id  out  IDW  index of the granted requester (valid while busy).
- done  out  1  one-cycle pulse marking the end of the operation.
- busy  out  1  high in every state other than IDLE.
- illegal_req  out  N_REQ  registered (req_set & req_clr); one cycle of latency.
- control  out  1  latch enable.
- s  out  1  latch set input.
- r  out  1  latch reset input.
- q_shadow  out  1  controller's copy of latch state.

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Reset values (all registered): gnt=0, gnt_id=0, done=0, busy=0, illegal_req=0, control=0, s=0, r=0, q_shadow=0. Also state=IDLE, rr pointer ptr=0, pulse counter=0.
- Reset mid-operation: abort immediately at the next edge. No done pulse; all outputs return to reset values.
- Eligibility: requester i is eligible when exactly one of req_set[i] or req_clr[i] is high. Both high means illegal: never eligible, and it is flagged only on illegal_req.
- Arbitration (IDLE only):
  - Search ptr, ptr+1, …, wrapping mod N_REQ; the first eligible requester wins.
  - On a win: latch op (1=set, 0=clear), gnt_id and one-hot gnt; go to SETUP. ptr <= (winner+1) mod N_REQ.
  - No eligible requester: stay in IDLE, ptr unchanged.
- FSM:
  - IDLE: control=0, s=0, r=0, busy=0.
  - SETUP (1 cycle): s=op, r=~op, control=0, busy=1.
  - PULSE (PULSE_CYC cycles): s/r unchanged, control=1. The counter counts 0..PULSE_CYC-1, then the FSM goes to HOLD.
  - HOLD (1 cycle): control=0, s/r still driven. done=1 this cycle, and q_shadow <= op. Next state IDLE, where gnt, s, r return to 0.
- Latency: requests are sampled at edge 0, and done is high during cycle PULSE_CYC+2. The back-to-back period is PULSE_CYC+3 cycles per operation.
- Request changes after grant:
  - Requester inputs are ignored while busy; op is frozen at grant.
  - A requester dropping its request after grant does not abort the operation.
  - A requester still asserting after its done competes again, at the lowest priority.
- Invariant: s & r == 0 in every cycle, and s/r are stable for every cycle in which control=1.

Optional Feature:
- Macro: SR_LATCH_CTRL_SKIP_REDUNDANT_EN.
- Defined: if the winner's op equals q_shadow, go IDLE -> HOLD directly.
  - HOLD then asserts done with control=0, s=0, r=0; the latch is untouched.
  - Latency is 2 cycles. Arbitration and pointer update are unchanged.
- Undefined: every grant runs the full SETUP/PULSE/HOLD sequence.

Test Plan:
- Single request, PULSE_CYC=2, reset released: req_set=0001 -> gnt=0001 from edge 1; s=1, r=0 from SETUP; control=1 for exactly 2 cycles. done in cycle 4, then q_shadow=1.
- Round robin: req_clr=1111 held continuously -> grants in order 0,1,2,3,0, each 5 cycles apart. gnt is always one-hot; done pulses once per grant.
- Illegal: req_set=req_clr=0100, others idle -> illegal_req=0100 one cycle later. No grant, busy=0, s=r=control=0 throughout.
- Reset mid-PULSE: assert reset while control=1 -> next edge gives control=s=r=0, gnt=0, busy=0, q_shadow=0. No done pulse; after release the first grant goes to requester 0.
- Mixed ops: requester 1 set, then requester 2 clear -> q_shadow goes 1 then 0. Monitor checks s&r==0 every cycle, and s/r stable while control=1.
- With SR_LATCH_CTRL_SKIP_REDUNDANT_EN: q_shadow=1, req_set=0010 -> done after 2 cycles with control never asserted. Without the macro the same stimulus takes PULSE_CYC+3 cycles.
